// File: rtl/dma_ctrl.sv
// DMA controller between the core, the shared data SRAM and an external DRAM port.
// Moves dmaWidth words DRAM->SRAM or SRAM->DRAM while stalling the core, then pulses dmaValid.
module dma_ctrl #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 10,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         dmaCmd,
  input  logic [31:0]        dmaSrcAddress,
  input  logic [31:0]        dmaDstAddress,
  input  logic [LEN_W-1:0]   dmaWidth,
  output logic               stall,
  output logic               dmaValid,
  input  logic [31:0]        coreSramAddress,
  input  logic [DATA_W-1:0]  coreSramWriteData,
  input  logic               coreSramWriteEnable,
  output logic [DATA_W-1:0]  coreSramReadData,
  output logic [SRAM_AW-1:0] sramAddress,
  output logic [DATA_W-1:0]  sramWriteData,
  output logic               sramWriteEnable,
  input  logic [DATA_W-1:0]  sramReadData,
  output logic [31:0]        dramAddress,
  output logic               dramReadEnable,
  output logic               dramWriteEnable,
  output logic [DATA_W-1:0]  dramWriteData,
  input  logic [DATA_W-1:0]  dramReadData,
  input  logic               dramReady
);

  typedef enum logic [2:0] {
    IDLE, D2S_RD, D2S_WR, S2D_RD, S2D_WR, DONE
  } stateT;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_D2S  = 2'b01,
    CMD_S2D  = 2'b10,
    CMD_RSVD = 2'b11
  } dmaCmdT;

  stateT             state, nextState;
  logic              armed;
  logic [31:0]       src, dst;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] buffer;
  logic              accept;
  logic              advance;

  // The core address is a full 32-bit byte address; only the low SRAM_AW bits reach the SRAM.
  logic unusedCoreAddrBits;
  assign unusedCoreAddrBits = &{1'b0, coreSramAddress[31:SRAM_AW]};

  assign coreSramReadData = sramReadData;

  assign accept = (state == IDLE) && armed &&
                  (dmaCmd == CMD_D2S || dmaCmd == CMD_S2D);

  // NOTE: every output gets a default before the case so no path leaves a signal
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    nextState       = state;
    advance         = 1'b0;
    stall           = 1'b0;
    dmaValid        = 1'b0;
    dramReadEnable  = 1'b0;
    dramWriteEnable = 1'b0;
    dramAddress     = src;
    dramWriteData   = buffer;
    sramAddress     = coreSramAddress[SRAM_AW-1:0];
    sramWriteData   = coreSramWriteData;
    sramWriteEnable = coreSramWriteEnable;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (dmaWidth == '0)          nextState = DONE;
          else if (dmaCmd == CMD_D2S)  nextState = D2S_RD;
          else                         nextState = S2D_RD;
        end
      end
      D2S_RD: begin
        stall           = 1'b1;
        dramReadEnable  = 1'b1;
        sramAddress     = dst[SRAM_AW-1:0];
        sramWriteData   = buffer;
        sramWriteEnable = 1'b0;
        if (dramReady) nextState = D2S_WR;
      end
      D2S_WR: begin
        stall           = 1'b1;
        advance         = 1'b1;
        sramAddress     = dst[SRAM_AW-1:0];
        sramWriteData   = buffer;
        sramWriteEnable = 1'b1;
        nextState       = (len == LEN_W'(1)) ? DONE : D2S_RD;
      end
      S2D_RD: begin
        stall           = 1'b1;
        sramAddress     = src[SRAM_AW-1:0];
        sramWriteData   = buffer;
        sramWriteEnable = 1'b0;
        nextState       = S2D_WR;
      end
      S2D_WR: begin
        stall           = 1'b1;
        dramWriteEnable = 1'b1;
        dramAddress     = dst;
        sramAddress     = src[SRAM_AW-1:0];
        sramWriteData   = buffer;
        sramWriteEnable = 1'b0;
        if (dramReady) begin
          advance   = 1'b1;
          nextState = (len == LEN_W'(1)) ? DONE : S2D_RD;
        end
      end
      DONE: begin
        dmaValid  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      armed  <= 1'b1;
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      buffer <= '0;
    end else begin
      state <= nextState;

      // Disarm on completion so a held command cannot restart until it returns to none.
      if (nextState == DONE && state != DONE) armed <= 1'b0;
      else if (dmaCmd == CMD_NONE)            armed <= 1'b1;

      if (accept) begin
        src <= dmaSrcAddress;
        dst <= dmaDstAddress;
        len <= dmaWidth;
      end

      if (state == D2S_RD && dramReady) buffer <= dramReadData;
      if (state == S2D_RD)              buffer <= sramReadData;

      if (advance) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        len <= len - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: SRAM/DRAM models plus a scoreboard of expected
// memory writes and completion pulses, compared in order as the DUT produces them.
module tb_dma_ctrl;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 10;
  localparam int SRAM_AW = 14;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [1:0]         dmaCmd = '0;
  logic [31:0]        dmaSrcAddress = '0;
  logic [31:0]        dmaDstAddress = '0;
  logic [LEN_W-1:0]   dmaWidth = '0;
  logic               stall, dmaValid;
  logic [31:0]        coreSramAddress = '0;
  logic [DATA_W-1:0]  coreSramWriteData = '0;
  logic               coreSramWriteEnable = 1'b0;
  logic [DATA_W-1:0]  coreSramReadData;
  logic [SRAM_AW-1:0] sramAddress;
  logic [DATA_W-1:0]  sramWriteData;
  logic               sramWriteEnable;
  logic [DATA_W-1:0]  sramReadData;
  logic [31:0]        dramAddress;
  logic               dramReadEnable, dramWriteEnable;
  logic [DATA_W-1:0]  dramWriteData, dramReadData;
  logic               dramReady;

  always #5 clk = ~clk;

  dma_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .reset(reset),
    .dmaCmd(dmaCmd), .dmaSrcAddress(dmaSrcAddress), .dmaDstAddress(dmaDstAddress),
    .dmaWidth(dmaWidth), .stall(stall), .dmaValid(dmaValid),
    .coreSramAddress(coreSramAddress), .coreSramWriteData(coreSramWriteData),
    .coreSramWriteEnable(coreSramWriteEnable), .coreSramReadData(coreSramReadData),
    .sramAddress(sramAddress), .sramWriteData(sramWriteData),
    .sramWriteEnable(sramWriteEnable), .sramReadData(sramReadData),
    .dramAddress(dramAddress), .dramReadEnable(dramReadEnable),
    .dramWriteEnable(dramWriteEnable), .dramWriteData(dramWriteData),
    .dramReadData(dramReadData), .dramReady(dramReady)
  );

  // Memory models: SRAM with async read / sync write, DRAM read-only pattern table.
  logic [31:0] sram [0:4095];
  logic [31:0] dram [0:255];
  bit          sramLoaded = 1'b0;

  always @(posedge clk) begin
    if (!sramLoaded) begin
      for (int i = 0; i < 4096; i++)
        sram[i] <= (i < 3) ? 32'(i + 5) : (i == 10) ? 32'h55 : 32'h0;
      sramLoaded <= 1'b1;
    end else if (sramWriteEnable) begin
      sram[sramAddress[13:2]] <= sramWriteData;
    end
  end

  assign sramReadData = sram[sramAddress[13:2]];
  assign dramReadData = dram[dramAddress[9:2]];

  int readyDelay = 0;
  int waitCnt = 0;
  assign dramReady = (dramReadEnable || dramWriteEnable) && (waitCnt >= readyDelay);
  always @(posedge clk) begin
    if ((dramReadEnable || dramWriteEnable) && !dramReady) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  int nCompared = 0;
  int nMismatched = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef enum logic [1:0] {EV_SRAM, EV_DRAM, EV_DONE} evKindT;
  typedef struct {
    evKindT      kind;
    logic [31:0] addr;
    logic [31:0] data;
  } evT;
  evT expQ[$];

  task automatic push(input evKindT k, input logic [31:0] a, input logic [31:0] d);
    evT e;
    e.kind = k; e.addr = a; e.data = d;
    expQ.push_back(e);
  endtask

  task automatic observe(input evKindT k, input logic [31:0] a, input logic [31:0] d);
    evT e;
    if (expQ.size() == 0) begin
      check("sb_unexpected_event", expQ.size(), 1);
    end else begin
      e = expQ.pop_front();
      check("sb_kind", k, e.kind);
      if (k != EV_DONE) begin
        check("sb_addr", a, e.addr);
        check("sb_data", d, e.data);
      end
    end
  endtask

  int busyCnt = 0;
  int dvCnt = 0;
  int sramWrites = 0;
  int rdWatchCnt = 0;
  logic [31:0] rdWatchAddr = 32'hFFFF_FFFF;

  always @(negedge clk) begin
    if (stall) busyCnt++;
    if (dramReadEnable && dramAddress == rdWatchAddr) rdWatchCnt++;
    if (reset) check("dram_excl", dramReadEnable & dramWriteEnable, 0);
    if (sramWriteEnable) begin
      sramWrites++;
      observe(EV_SRAM, {18'b0, sramAddress}, sramWriteData);
    end
    if (dramWriteEnable && dramReady) observe(EV_DRAM, dramAddress, dramWriteData);
    if (dmaValid) begin
      dvCnt++;
      observe(EV_DONE, 32'h0, 32'h0);
    end
  end

  // Called at posedge+1; drives a command across one accept edge.
  task automatic issue(input logic [1:0] cmd, input logic [31:0] s, input logic [31:0] d,
                       input logic [LEN_W-1:0] w, input bit hold);
    dmaCmd = cmd; dmaSrcAddress = s; dmaDstAddress = d; dmaWidth = w;
    @(posedge clk); #1;
    if (!hold) dmaCmd = 2'b00;
  endtask

  task automatic waitDone(input int budget, output int cycles, output int busy);
    int b0;
    bit seen;
    b0 = busyCnt; cycles = 0; seen = 1'b0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (dmaValid) seen = 1'b1;
    end
    if (!seen) check("done_timeout", dmaValid, 1);
    #1;
    busy = busyCnt - b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, busy, dv0, b0, s0, guard;

    for (int i = 0; i < 256; i++) dram[i] = 32'hD000_0000 + 32'(i);
    dram[4] = 32'd1234;
    dram[8] = 32'h0000_ABCD;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_dmaValid", dmaValid, 0);
    check("rst_dramRe", dramReadEnable, 0);
    check("rst_dramWe", dramWriteEnable, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // D2S single word
    push(EV_SRAM, 32'd24, 32'd1234);
    push(EV_DONE, 0, 0);
    issue(2'b01, 32'd16, 32'd24, 10'd1, 1'b0);
    waitDone(50, cyc, busy);
    check("t1_busy", busy, 2);
    check("t1_latency", cyc, 3);
    check("t1_sram24", sram[6], 32'd1234);
    check("t1_stall_after", stall, 0);

    // S2D three words
    push(EV_DRAM, 32'h100, 32'd5);
    push(EV_DRAM, 32'h104, 32'd6);
    push(EV_DRAM, 32'h108, 32'd7);
    push(EV_DONE, 0, 0);
    issue(2'b10, 32'd0, 32'h100, 10'd3, 1'b0);
    waitDone(50, cyc, busy);
    check("t2_busy", busy, 6);
    check("t2_latency", cyc, 7);
    check("t2_queue", expQ.size(), 0);

    // D2S with slow DRAM
    readyDelay = 4; rdWatchAddr = 32'd32; rdWatchCnt = 0;
    push(EV_SRAM, 32'd48, 32'h0000_ABCD);
    push(EV_DONE, 0, 0);
    issue(2'b01, 32'd32, 32'd48, 10'd1, 1'b0);
    waitDone(100, cyc, busy);
    check("t3_rd_hold", rdWatchCnt, 5);
    check("t3_busy", busy, 6);
    check("t3_sram48", sram[12], 32'h0000_ABCD);
    readyDelay = 0; rdWatchAddr = 32'hFFFF_FFFF;

    // Zero length, command held high after completion
    push(EV_DONE, 0, 0);
    issue(2'b01, 32'd64, 32'd64, 10'd0, 1'b1);
    waitDone(20, cyc, busy);
    check("t4_latency", cyc, 1);
    check("t4_busy", busy, 0);
    dv0 = dvCnt; b0 = busyCnt;
    repeat (10) @(posedge clk);
    #1;
    check("t4_no_rerun_dv", dvCnt - dv0, 0);
    check("t4_no_rerun_busy", busyCnt - b0, 0);
    dmaCmd = 2'b00;
    @(posedge clk); #1;
    push(EV_DONE, 0, 0);
    issue(2'b01, 32'd64, 32'd64, 10'd0, 1'b0);
    waitDone(20, cyc, busy);
    check("t4_rearm_latency", cyc, 1);

    // Core write suppressed while busy, lands when idle
    readyDelay = 2;
    push(EV_SRAM, 32'd80, dram[16]);
    push(EV_SRAM, 32'd84, dram[17]);
    push(EV_DONE, 0, 0);
    issue(2'b01, 32'd64, 32'd80, 10'd2, 1'b0);
    coreSramAddress = 32'd40; coreSramWriteData = 32'hDEAD; coreSramWriteEnable = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    coreSramWriteEnable = 1'b0;
    waitDone(100, cyc, busy);
    check("t5_sram40_kept", sram[10], 32'h55);
    check("t5_sram84", sram[21], dram[17]);
    push(EV_SRAM, 32'd40, 32'hDEAD);
    coreSramWriteEnable = 1'b1;
    @(posedge clk); #1;
    coreSramWriteEnable = 1'b0;
    check("t5_sram40_core", sram[10], 32'hDEAD);
    check("t5_readback", coreSramReadData, 32'hDEAD);
    readyDelay = 0;

    // Reset mid-transfer after two words
    push(EV_SRAM, 32'd200, dram[32]);
    push(EV_SRAM, 32'd204, dram[33]);
    s0 = sramWrites; guard = 0;
    issue(2'b01, 32'd128, 32'd200, 10'd4, 1'b0);
    while (sramWrites - s0 < 2 && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    check("t6_two_words_seen", sramWrites - s0, 2);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_stall", stall, 0);
    check("t6_rst_dramRe", dramReadEnable, 0);
    check("t6_rst_dmaValid", dmaValid, 0);
    reset = 1'b1;
    dv0 = dvCnt;
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_done", dvCnt - dv0, 0);
    check("t6_word3", sram[52], 32'h0);
    check("t6_word4", sram[53], 32'h0);
    check("t6_queue", expQ.size(), 0);

    // Reserved command is ignored
    b0 = busyCnt; dv0 = dvCnt;
    dmaCmd = 2'b11; dmaWidth = 10'd1;
    repeat (10) @(posedge clk);
    #1;
    check("t7_rsvd_busy", busyCnt - b0, 0);
    check("t7_rsvd_dv", dvCnt - dv0, 0);
    dmaCmd = 2'b00;
    @(posedge clk); #1;
    check("final_queue", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
